// File: rtl/dec24_pkg.sv
// Shared types and helpers for the dec24_pipe 2-to-4 decoder pipeline.
// Holds the controller state enum, default sizing and the decode function.
package dec24_pkg;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      SCAN = 1'b1
   } state_t;

   localparam int DEF_DEPTH = 2;
   localparam int DEF_CNT_W = 8;

   function automatic logic [3:0] code2onehot(input logic [1:0] code, input logic en);
      code2onehot = en ? (4'b0001 << code) : 4'b0000;
   endfunction

endpackage

// File: rtl/dec24_pipe_if.sv
// Handshake bundle between the decoder pipeline and its producer/consumer.
// The slave side is the pipeline; the master side drives beats and drains output.
interface dec24_pipe_if #(
   parameter int CNT_W = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [1:0]       in_code;
   logic             in_en;
   logic             scan_start;
   logic             scan_busy;
   logic             out_valid;
   logic             out_ready;
   logic [3:0]       out_onehot;
   logic [CNT_W-1:0] beat_cnt;

   modport slave (
      input  in_valid, in_code, in_en, scan_start, out_ready,
      output in_ready, scan_busy, out_valid, out_onehot, beat_cnt
   );

   modport master (
      output in_valid, in_code, in_en, scan_start, out_ready,
      input  in_ready, scan_busy, out_valid, out_onehot, beat_cnt
   );
endinterface

// File: rtl/dec24_fifo.sv
// Synchronous FIFO holding decoded 4-bit words; DEPTH must be a power of two.
// Pushes while full and pops while empty are dropped so the pointers stay coherent.
module dec24_fifo
   import dec24_pkg::*;
#(
   parameter int DEPTH = DEF_DEPTH
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       push,
   input  logic [3:0] push_data,
   input  logic       pop,
   output logic [3:0] head,
   output logic       full,
   output logic       empty
);
   localparam int AW = $clog2(DEPTH);

   logic [3:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic          do_push;
   logic          do_pop;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end
endmodule

// File: rtl/dec24_pipe.sv
// 2-to-4 one-hot decoder feeding an output FIFO, with a scan mode that emits
// every one-hot word in order. Counts delivered output beats.
//
// state | meaning
// IDLE  | accepting external beats; scan_start launches a scan
// SCAN  | pushing 0001,0010,0100,1000 as space allows; external input held off
module dec24_pipe
   import dec24_pkg::*;
#(
   parameter int DEPTH = DEF_DEPTH,
   parameter int CNT_W = DEF_CNT_W
) (
   input logic          clk,
   input logic          rst,
   dec24_pipe_if.slave  bus
);
   state_t           state_q, state_d;
   logic [1:0]       idx_q, idx_d;
   logic [CNT_W-1:0] cnt_q;
   logic             full, empty;
   logic [3:0]       head;
   logic             in_ready;
   logic             ext_push, scan_push, push, pop;
   logic [3:0]       push_data;

   // rst is folded in so no beat is acknowledged while the FIFO is being cleared
   assign in_ready  = (state_q == IDLE) && !full && !rst;
   assign ext_push  = bus.in_valid && in_ready;
   assign scan_push = (state_q == SCAN) && !full;
   assign push      = ext_push || scan_push;
   assign push_data = scan_push ? (4'b0001 << idx_q) : code2onehot(bus.in_code, bus.in_en);
   assign pop       = !empty && bus.out_ready;

   dec24_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (push_data),
      .pop       (pop),
      .head      (head),
      .full      (full),
      .empty     (empty)
   );

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      case (state_q)
         IDLE: begin
            if (bus.scan_start) begin
               state_d = SCAN;
               idx_d   = 2'd0;
            end
         end
         SCAN: begin
            if (!full) begin
               idx_d = idx_q + 2'd1;
               if (idx_q == 2'd3) state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= 2'd0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         if (pop) cnt_q <= cnt_q + 1'b1;
      end
   end

   assign bus.in_ready   = in_ready;
   assign bus.scan_busy  = (state_q == SCAN);
   assign bus.out_valid  = !empty;
   assign bus.out_onehot = empty ? 4'b0000 : head;
   assign bus.beat_cnt   = cnt_q;
endmodule

// File: tb/tb_dec24_pipe.sv
// Directed bench for dec24_pipe: per-cycle vector table for decode and
// backpressure, plus hand-written scan, reset-mid-scan and counter-wrap sequences.
module tb_dec24_pipe;
   import dec24_pkg::*;

   localparam int DEPTH = 2;
   localparam int CNT_W = 8;
   localparam int NV    = 15;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   dec24_pipe_if #(.CNT_W(CNT_W)) bus ();

   dec24_pipe #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic       iv;
      logic [1:0] code;
      logic       en;
      logic       ordy;
      logic       e_ir;
      logic       e_ov;
      logic [3:0] e_oh;
      logic [7:0] e_cnt;
   } vec_t;

   vec_t vt [NV];

   int checks   = 0;
   int failures = 0;

   // scan sequence expectations, one entry per cycle
   logic       s_iv   [8] = '{1, 1, 1, 1, 1, 1, 0, 0};
   logic       s_ss   [8] = '{1, 0, 1, 0, 0, 0, 0, 0};
   logic       s_busy [8] = '{0, 1, 1, 1, 1, 0, 0, 0};
   logic       s_ir   [8] = '{1, 0, 0, 0, 0, 1, 1, 1};
   logic       s_ov   [8] = '{0, 1, 1, 1, 1, 1, 1, 0};
   logic [3:0] s_oh   [8] = '{4'h0, 4'h2, 4'h1, 4'h2, 4'h4, 4'h8, 4'h2, 4'h0};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic iv, input logic [1:0] code, input logic en,
                        input logic ordy, input logic ss);
      bus.in_valid   = iv;
      bus.in_code    = code;
      bus.in_en      = en;
      bus.out_ready  = ordy;
      bus.scan_start = ss;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int mism;
      logic [3:0] exp_oh;

      //          iv code en  ordy ir ov  oh    cnt
      vt[0]  = '{1, 2'd0, 1, 1, 1, 0, 4'h0, 8'd0};
      vt[1]  = '{1, 2'd1, 1, 1, 1, 1, 4'h1, 8'd0};
      vt[2]  = '{1, 2'd2, 1, 1, 1, 1, 4'h2, 8'd1};
      vt[3]  = '{1, 2'd3, 1, 1, 1, 1, 4'h4, 8'd2};
      vt[4]  = '{0, 2'd0, 1, 1, 1, 1, 4'h8, 8'd3};
      vt[5]  = '{1, 2'd2, 0, 1, 1, 0, 4'h0, 8'd4};
      vt[6]  = '{0, 2'd0, 1, 1, 1, 1, 4'h0, 8'd4};
      vt[7]  = '{0, 2'd0, 1, 0, 1, 0, 4'h0, 8'd5};
      vt[8]  = '{1, 2'd0, 1, 0, 1, 0, 4'h0, 8'd5};
      vt[9]  = '{1, 2'd1, 1, 0, 1, 1, 4'h1, 8'd5};
      vt[10] = '{1, 2'd3, 1, 0, 0, 1, 4'h1, 8'd5};
      vt[11] = '{1, 2'd3, 1, 1, 0, 1, 4'h1, 8'd5};
      vt[12] = '{1, 2'd3, 1, 1, 1, 1, 4'h2, 8'd6};
      vt[13] = '{0, 2'd0, 1, 1, 1, 1, 4'h8, 8'd7};
      vt[14] = '{0, 2'd0, 1, 1, 1, 0, 4'h0, 8'd8};

      rst = 1'b1;
      drive(0, 2'd0, 0, 0, 0);
      @(negedge clk);
      chk("in_ready_in_reset", 32'(bus.in_ready), 32'd0);
      next_cycle();
      next_cycle();
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_out_onehot", 32'(bus.out_onehot), 32'd0);
      chk("rst_scan_busy", 32'(bus.scan_busy), 32'd0);
      chk("rst_beat_cnt", 32'(bus.beat_cnt), 32'd0);
      rst = 1'b0;

      for (int i = 0; i < NV; i++) begin
         drive(vt[i].iv, vt[i].code, vt[i].en, vt[i].ordy, 1'b0);
         @(negedge clk);
         chk($sformatf("vec%0d_in_ready", i), 32'(bus.in_ready), 32'(vt[i].e_ir));
         chk($sformatf("vec%0d_out_valid", i), 32'(bus.out_valid), 32'(vt[i].e_ov));
         chk($sformatf("vec%0d_out_onehot", i), 32'(bus.out_onehot), 32'(vt[i].e_oh));
         chk($sformatf("vec%0d_beat_cnt", i), 32'(bus.beat_cnt), 32'(vt[i].e_cnt));
         next_cycle();
      end

      // scan with an external beat held on in_valid; second scan_start ignored
      for (int c = 0; c < 8; c++) begin
         drive(s_iv[c], 2'd1, 1, 1, s_ss[c]);
         @(negedge clk);
         chk($sformatf("scan%0d_busy", c), 32'(bus.scan_busy), 32'(s_busy[c]));
         chk($sformatf("scan%0d_in_ready", c), 32'(bus.in_ready), 32'(s_ir[c]));
         chk($sformatf("scan%0d_out_valid", c), 32'(bus.out_valid), 32'(s_ov[c]));
         chk($sformatf("scan%0d_out_onehot", c), 32'(bus.out_onehot), 32'(s_oh[c]));
         next_cycle();
      end
      chk("scan_beat_cnt", 32'(bus.beat_cnt), 32'd14);

      // reset after two scan pushes with output stalled
      drive(0, 2'd0, 1, 0, 1);
      @(negedge clk);
      chk("rs_c0_busy", 32'(bus.scan_busy), 32'd0);
      next_cycle();
      drive(0, 2'd0, 1, 0, 0);
      @(negedge clk);
      chk("rs_c1_busy", 32'(bus.scan_busy), 32'd1);
      chk("rs_c1_out_valid", 32'(bus.out_valid), 32'd0);
      next_cycle();
      @(negedge clk);
      chk("rs_c2_out_onehot", 32'(bus.out_onehot), 32'h1);
      next_cycle();
      rst = 1'b1;
      drive(1, 2'd0, 1, 0, 0);
      @(negedge clk);
      chk("rs_in_ready_in_reset", 32'(bus.in_ready), 32'd0);
      next_cycle();
      rst = 1'b0;
      drive(0, 2'd0, 1, 0, 0);
      @(negedge clk);
      chk("rs_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rs_scan_busy", 32'(bus.scan_busy), 32'd0);
      chk("rs_beat_cnt", 32'(bus.beat_cnt), 32'd0);
      chk("rs_out_onehot", 32'(bus.out_onehot), 32'd0);
      next_cycle();
      @(negedge clk);
      chk("rs_stay_idle", 32'(bus.scan_busy), 32'd0);
      chk("rs_stay_empty", 32'(bus.out_valid), 32'd0);
      chk("rs_in_ready", 32'(bus.in_ready), 32'd1);
      next_cycle();

      // 256 streaming beats: beat_cnt must wrap back to 0
      mism = 0;
      for (int i = 0; i <= 256; i++) begin
         drive(i < 256, 2'(i), 1, 1, 0);
         @(negedge clk);
         if (i >= 1) begin
            exp_oh = 4'(1 << ((i - 1) % 4));
            if (bus.out_valid !== 1'b1 || bus.out_onehot !== exp_oh) mism++;
         end
         if (i == 256) chk("wrap_cnt_255", 32'(bus.beat_cnt), 32'd255);
         next_cycle();
      end
      chk("wrap_data", 32'(mism), 32'd0);
      @(negedge clk);
      chk("wrap_cnt_0", 32'(bus.beat_cnt), 32'd0);
      chk("wrap_empty", 32'(bus.out_valid), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/dec24_pipe.md
DEC24_PIPE -- requirements
Module: dec24_pipe

Interface
REQ-001 Parameter DEPTH, default 2: output buffer entries; power of two, at least 2.
REQ-002 Parameter CNT_W, default 8: width of beat_cnt.
REQ-003 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 Port rst, input, 1: reset, synchronous and active-high.
REQ-005 Port in_valid, input, 1: input beat offered.
REQ-006 Port in_ready, output, 1: block accepts an input beat this cycle.
REQ-007 Port in_code, input, 2: binary code to decode.
REQ-008 Port in_en, input, 1: decode enable, sampled with the beat; 0 yields an all-zero word.
REQ-009 Port scan_start, input, 1: one-cycle request to emit the full one-hot sequence.
REQ-010 Port scan_busy, output, 1: high while the scan sequence is being generated.
REQ-011 Port out_valid, output, 1: buffer head valid.
REQ-012 Port out_ready, input, 1: downstream accepts the head.
REQ-013 Port out_onehot, output, 4: decoded word at the buffer head.
REQ-014 Port beat_cnt, output, CNT_W: count of output beats delivered, modulo 2^CNT_W.

Function
REQ-015 Decode rule: in_en=1 maps code 00/01/10/11 to 0001/0010/0100/1000; in_en=0 maps any code to 0000.
REQ-016 Push condition: a push occurs on in_valid && in_ready.
REQ-017 Pop condition: a pop occurs on out_valid && out_ready.
REQ-018 Input gating: in_ready = (state==IDLE) && !full; no combinational path from out_ready.
REQ-019 Output valid: out_valid = !empty.
REQ-020 Head word: out_onehot equals the head entry when out_valid=1, and 0000 otherwise.
REQ-021 Latency: a beat pushed at edge N is visible at the head one cycle later, when the buffer was empty.
REQ-022 Buffer ordering: FIFO order is preserved; with no pops, occupancy after DEPTH pushes is DEPTH (full).
REQ-023 Simultaneous push and pop: when not full, occupancy is unchanged and both operations take effect.
REQ-024 Full and empty boundaries: no push occurs when full; no pop occurs when empty; pointers wrap modulo DEPTH.
REQ-025 State machine, IDLE to SCAN: on scan_start=1 in IDLE, go to SCAN and clear the scan index to 0; scan_start outside IDLE is ignored.
REQ-026 State machine, in SCAN: each cycle the buffer is not full, push 1<<idx and increment idx; after idx=3 is pushed, return to IDLE.
REQ-027 External input during SCAN: in_ready=0, so external beats are held, not dropped.
REQ-028 scan_busy: scan_busy = (state==SCAN).
REQ-029 Simultaneous scan request and input beat in IDLE: the input beat is pushed that cycle and SCAN starts the next cycle.
REQ-030 beat_cnt: increments by 1 per pop and wraps from 2^CNT_W-1 to 0.

Reset
REQ-031 Reset values: rst=1 at an edge sets state=IDLE, occupancy=0, pointers=0, idx=0, beat_cnt=0.
REQ-032 Outputs after reset edge: out_valid=0, out_onehot=0000, scan_busy=0.
REQ-033 Reset mid-operation: reset during SCAN or with buffer data aborts the scan and discards all buffered entries.
REQ-034 in_ready during reset: in_ready=0 while rst=1.

Structure
REQ-035 Shared package dec24_pkg: holds the state enum (IDLE, SCAN), default DEPTH/CNT_W constants and the code-to-one-hot function.
REQ-036 Buffer sub-module: the buffer is a single sub-module dec24_fifo (synchronous FIFO, 4-bit data, DEPTH entries, push/pop/full/empty).

Verification
REQ-037 Basic decode: push codes 00,01,10,11 with en=1 and out_ready=1 -> out_onehot 0001,0010,0100,1000 on consecutive cycles; beat_cnt=4.
REQ-038 Disabled decode: push code 10 with en=0 -> one beat of 0000.
REQ-039 Backpressure: out_ready=0, push 3 beats -> in_ready falls after 2; release out_ready -> beats delivered in order, none lost or duplicated.
REQ-040 Scan sequence: pulse scan_start with in_valid=1 code 01 held -> output 0010, then 0001,0010,0100,1000; scan_busy high 4 cycles with out_ready=1.
REQ-041 Reset mid-scan: assert rst after 2 scan pushes -> next cycle out_valid=0, scan_busy=0, beat_cnt=0.
REQ-042 Counter wrap: 256 pops with CNT_W=8 -> beat_cnt returns to 0.
